// File: rtl/branch_outcome_tracker.sv
// branch_outcome_tracker
// Holds an in-order queue of conditional branches with the predictions made at
// fetch. When the oldest branch resolves, both component predictors are graded
// against the actual direction, and one registered chooser update is emitted on
// the following cycle.
//
// Handshake: a fetch is accepted on a cycle where fetch_valid & fetch_ready &
// ~flush. fetch_ready is taken from the registered occupancy only, so a pop in
// the same cycle does not make room for a push. The resolve side has no ready
// signal. res_valid asks for the head entry to be popped, and that request is
// honoured whenever the queue is not empty. The update side has no
// back-pressure: upd_valid is a one-cycle strobe.
module branch_outcome_tracker #(
  parameter int IDX_W = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid,
  input  logic [IDX_W-1:0]         fetch_idx,
  input  logic                     fetch_pred1,
  input  logic                     fetch_pred2,
  input  logic                     fetch_choice,
  output logic                     fetch_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic                     flush,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_past,
  output logic                     upd_taken1,
  output logic                     upd_taken2,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Entry storage, indexed by the low pointer bits
  logic [IDX_W-1:0] r_idx_mem [DEPTH];
  logic [DEPTH-1:0] r_p1_mem;
  logic [DEPTH-1:0] r_p2_mem;
  logic [DEPTH-1:0] r_ch_mem;

  // Pointers carry one extra wrap bit, so full and empty can be told apart
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;

  logic             r_upd_valid;
  logic [IDX_W-1:0] r_upd_past;
  logic             r_upd_taken1;
  logic             r_upd_taken2;
  logic             r_mispredict;
  logic             r_err;

  logic [PW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_err_set;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_rd_addr;
  logic             w_head_p1;
  logic             w_head_p2;
  logic             w_head_ch;
  logic             w_head_sel;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_count == PW'(DEPTH));
  assign w_empty   = (w_count == '0);
  assign w_wr_addr = r_wr_ptr[AW-1:0];
  assign w_rd_addr = r_rd_ptr[AW-1:0];

  // A flush suppresses any fetch in the same cycle, and it does not count as an overflow
  assign w_push    = fetch_valid & ~w_full & ~flush;
  assign w_pop     = res_valid & ~w_empty;
  assign w_err_set = (fetch_valid & w_full & ~flush) | (res_valid & w_empty);

  assign w_head_p1  = r_p1_mem[w_rd_addr];
  assign w_head_p2  = r_p2_mem[w_rd_addr];
  assign w_head_ch  = r_ch_mem[w_rd_addr];
  assign w_head_sel = w_head_ch ? w_head_p2 : w_head_p1;

  // Write the accepted fetch into the tail slot
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_idx_mem[w_wr_addr] <= fetch_idx;
      r_p1_mem[w_wr_addr]  <= fetch_pred1;
      r_p2_mem[w_wr_addr]  <= fetch_pred2;
      r_ch_mem[w_wr_addr]  <= fetch_choice;
    end
  end

  // Move the pointers. A flush resets both to zero, after any same-cycle pop has read the head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Grade the popped head entry; the payload holds its value while no update is emitted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_valid  <= 1'b0;
      r_upd_past   <= '0;
      r_upd_taken1 <= 1'b0;
      r_upd_taken2 <= 1'b0;
      r_mispredict <= 1'b0;
    end else begin
      r_upd_valid <= w_pop;
      if (w_pop) begin
        r_upd_past   <= r_idx_mem[w_rd_addr];
        r_upd_taken1 <= (w_head_p1 == res_taken);
        r_upd_taken2 <= (w_head_p2 == res_taken);
        r_mispredict <= (w_head_sel != res_taken);
      end
    end
  end

  // Sticky protocol error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  assign fetch_ready = ~w_full;
  assign count       = w_count;
  assign upd_valid   = r_upd_valid;
  assign upd_past    = r_upd_past;
  assign upd_taken1  = r_upd_taken1;
  assign upd_taken2  = r_upd_taken2;
  assign mispredict  = r_mispredict;
  assign err         = r_err;

endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Bench for branch_outcome_tracker. It has three phases: a table of hand-derived
// vectors, hand-written flush and reset sequences, and random traffic checked
// against a queue-based model.
module tb_branch_outcome_tracker;

  localparam int IDX_W = 12;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             fetch_valid;
  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_pred1;
  logic             fetch_pred2;
  logic             fetch_choice;
  logic             fetch_ready;
  logic             res_valid;
  logic             res_taken;
  logic             flush;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_past;
  logic             upd_taken1;
  logic             upd_taken2;
  logic             mispredict;
  logic [CW-1:0]    count;
  logic             err;

  int n_vec;
  int n_miss;

  branch_outcome_tracker #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_idx(fetch_idx),
    .fetch_pred1(fetch_pred1), .fetch_pred2(fetch_pred2),
    .fetch_choice(fetch_choice), .fetch_ready(fetch_ready),
    .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .upd_valid(upd_valid), .upd_past(upd_past),
    .upd_taken1(upd_taken1), .upd_taken2(upd_taken2),
    .mispredict(mispredict), .count(count), .err(err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard helper
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic fv, input logic [IDX_W-1:0] idx, input logic p1,
                       input logic p2, input logic ch, input logic rv, input logic rt,
                       input logic fl);
    fetch_valid = fv; fetch_idx = idx; fetch_pred1 = p1; fetch_pred2 = p2;
    fetch_choice = ch; res_valid = rv; res_taken = rt; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, '0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", fetch_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_past", upd_past, 0);
    chk("rst_misp", mispredict, 0);
    rst_n = 1'b1;
    tick();
  endtask

  // Table-driven vectors
  typedef struct {
    logic             fv;
    logic [IDX_W-1:0] idx;
    logic             p1, p2, ch;
    logic             rv, rt, fl;
    logic             e_uv;
    logic [IDX_W-1:0] e_past;
    logic             e_t1, e_t2, e_mp;
    logic [CW-1:0]    e_cnt;
    logic             e_rdy, e_err;
  } vec_t;

  function automatic vec_t mk(input logic fv, input logic [IDX_W-1:0] idx,
                              input logic p1, input logic p2, input logic ch,
                              input logic rv, input logic rt, input logic e_uv,
                              input logic [IDX_W-1:0] e_past, input logic e_t1,
                              input logic e_t2, input logic e_mp, input logic [CW-1:0] e_cnt,
                              input logic e_rdy, input logic e_err);
    vec_t v;
    v.fv = fv; v.idx = idx; v.p1 = p1; v.p2 = p2; v.ch = ch;
    v.rv = rv; v.rt = rt; v.fl = 1'b0;
    v.e_uv = e_uv; v.e_past = e_past; v.e_t1 = e_t1; v.e_t2 = e_t2; v.e_mp = e_mp;
    v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_err = e_err;
    return v;
  endfunction

  vec_t vt[15];

  // Behavioural model: queue of packed {idx, pred1, pred2, choice}
  logic [IDX_W+2:0] exp_q[$];
  logic             m_err;
  logic [IDX_W-1:0] m_past;
  logic             m_t1, m_t2, m_mp;

  task automatic model_step(input logic fv, input logic [IDX_W-1:0] idx, input logic p1,
                            input logic p2, input logic ch, input logic rv, input logic rt,
                            input logic fl, output logic uv);
    logic [IDX_W+2:0] e;
    logic             sel;
    int               sz;
    sz = exp_q.size();
    uv = 1'b0;
    if (rv) begin
      if (sz == 0) m_err = 1'b1;
      else begin
        e      = exp_q.pop_front();
        uv     = 1'b1;
        m_past = e[IDX_W+2:3];
        m_t1   = (e[2] == rt);
        m_t2   = (e[1] == rt);
        sel    = e[0] ? e[1] : e[2];
        m_mp   = (sel != rt);
      end
    end
    if (fl) exp_q.delete();
    else if (fv) begin
      if (sz == DEPTH) m_err = 1'b1;
      else exp_q.push_back({idx, p1, p2, ch});
    end
  endtask

  initial begin
    logic             e_uv;
    logic             r_fv, r_p1, r_p2, r_ch, r_rv, r_rt, r_fl;
    logic [IDX_W-1:0] r_idx;
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0, 0, 0, 0);

    //           fv idx     p1 p2 ch rv rt  uv past   t1 t2 mp cnt rdy err
    vt[0]  = mk(1, 12'h0A5, 1, 0, 0, 0, 0,  0, 12'h0, 0, 0, 0, 1, 1, 0);
    vt[1]  = mk(0, 12'h0,   0, 0, 0, 1, 1,  1, 12'h0A5, 1, 0, 0, 0, 1, 0);
    vt[2]  = mk(1, 12'h7FF, 0, 1, 0, 0, 0,  0, 12'h0, 0, 0, 0, 1, 1, 0);
    vt[3]  = mk(0, 12'h0,   0, 0, 0, 1, 1,  1, 12'h7FF, 0, 1, 1, 0, 1, 0);
    vt[4]  = mk(1, 12'h001, 1, 1, 1, 0, 0,  0, 12'h0, 0, 0, 0, 1, 1, 0);
    vt[5]  = mk(1, 12'h002, 0, 0, 1, 0, 0,  0, 12'h0, 0, 0, 0, 2, 1, 0);
    vt[6]  = mk(1, 12'h003, 1, 0, 1, 0, 0,  0, 12'h0, 0, 0, 0, 3, 1, 0);
    vt[7]  = mk(1, 12'h004, 0, 1, 0, 0, 0,  0, 12'h0, 0, 0, 0, 4, 0, 0);
    vt[8]  = mk(1, 12'h005, 1, 1, 1, 0, 0,  0, 12'h0, 0, 0, 0, 4, 0, 1);
    vt[9]  = mk(1, 12'h006, 0, 0, 0, 1, 1,  1, 12'h001, 1, 1, 0, 3, 1, 1);
    vt[10] = mk(1, 12'h007, 1, 1, 0, 1, 0,  1, 12'h002, 1, 1, 0, 3, 1, 1);
    vt[11] = mk(0, 12'h0,   0, 0, 0, 1, 0,  1, 12'h003, 0, 1, 0, 2, 1, 1);
    vt[12] = mk(0, 12'h0,   0, 0, 0, 1, 0,  1, 12'h004, 1, 0, 0, 1, 1, 1);
    vt[13] = mk(0, 12'h0,   0, 0, 0, 1, 1,  1, 12'h007, 1, 1, 0, 0, 1, 1);
    vt[14] = mk(0, 12'h0,   0, 0, 0, 0, 0,  0, 12'h0, 0, 0, 0, 0, 1, 1);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].fv, vt[i].idx, vt[i].p1, vt[i].p2, vt[i].ch, vt[i].rv, vt[i].rt, vt[i].fl);
      tick();
      chk($sformatf("tbl%0d_uv", i), upd_valid, vt[i].e_uv);
      chk($sformatf("tbl%0d_cnt", i), count, vt[i].e_cnt);
      chk($sformatf("tbl%0d_rdy", i), fetch_ready, vt[i].e_rdy);
      chk($sformatf("tbl%0d_err", i), err, vt[i].e_err);
      if (vt[i].e_uv) begin
        chk($sformatf("tbl%0d_past", i), upd_past, vt[i].e_past);
        chk($sformatf("tbl%0d_t1", i), upd_taken1, vt[i].e_t1);
        chk($sformatf("tbl%0d_t2", i), upd_taken2, vt[i].e_t2);
        chk($sformatf("tbl%0d_mp", i), mispredict, vt[i].e_mp);
      end
    end
    // payload holds after the last update
    chk("hold_past", upd_past, 12'h007);

    // Flush alone with a fetch: queue cleared, the fetch is ignored, err stays clear
    do_reset();
    drive(1, 12'h020, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 12'h021, 0, 0, 0, 0, 0, 1); tick();
    chk("flush_cnt", count, 0);
    chk("flush_uv", upd_valid, 0);
    chk("flush_err", err, 0);

    // Three entries, then flush with resolve: one update for the oldest, then empty
    drive(1, 12'h010, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 12'h011, 0, 1, 1, 0, 0, 0); tick();
    drive(1, 12'h012, 1, 1, 0, 0, 0, 0); tick();
    chk("fr_pre_cnt", count, 3);
    drive(0, '0, 0, 0, 0, 1, 0, 1); tick();
    chk("fr_uv", upd_valid, 1);
    chk("fr_past", upd_past, 12'h010);
    chk("fr_t1", upd_taken1, 0);
    chk("fr_t2", upd_taken2, 1);
    chk("fr_mp", mispredict, 1);
    chk("fr_cnt", count, 0);
    drive(0, '0, 0, 0, 0, 0, 0, 0); tick();
    chk("fr_single", upd_valid, 0);
    drive(0, '0, 0, 0, 0, 1, 1, 0); tick();
    chk("empty_res_uv", upd_valid, 0);
    chk("empty_res_err", err, 1);
    chk("empty_res_past", upd_past, 12'h010);

    // Random traffic against the model, with a reset pulse in the middle of the stream
    do_reset();
    exp_q.delete();
    m_err = 0; m_past = '0; m_t1 = 0; m_t2 = 0; m_mp = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        drive(1, 12'h3C3, 1, 1, 1, 1, 1, 0);
        model_step(1, 12'h3C3, 1, 1, 1, 1, 1, 0, e_uv);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_uv", upd_valid, 0);
        chk("midrst_cnt", count, 0);
        chk("midrst_rdy", fetch_ready, 1);
        chk("midrst_err", err, 0);
        exp_q.delete();
        m_err = 0; m_past = '0; m_t1 = 0; m_t2 = 0; m_mp = 0;
        drive(0, '0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
      end
      r_fv  = ($urandom_range(0, 99) < 60);
      r_idx = IDX_W'($urandom_range(0, 4095));
      r_p1  = 1'($urandom_range(0, 1));
      r_p2  = 1'($urandom_range(0, 1));
      r_ch  = 1'($urandom_range(0, 1));
      r_rv  = ($urandom_range(0, 99) < 50);
      r_rt  = 1'($urandom_range(0, 1));
      r_fl  = ($urandom_range(0, 99) < 4);
      drive(r_fv, r_idx, r_p1, r_p2, r_ch, r_rv, r_rt, r_fl);
      model_step(r_fv, r_idx, r_p1, r_p2, r_ch, r_rv, r_rt, r_fl, e_uv);
      tick();
      chk("rnd_uv", upd_valid, e_uv);
      chk("rnd_cnt", count, exp_q.size());
      chk("rnd_rdy", fetch_ready, exp_q.size() != DEPTH);
      chk("rnd_err", err, m_err);
      chk("rnd_past", upd_past, m_past);
      chk("rnd_t1", upd_taken1, m_t1);
      chk("rnd_t2", upd_taken2, m_t2);
      chk("rnd_mp", mispredict, m_mp);
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
